// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//
// Multi-channel edge detector for slow control/status inputs. Each channel
// runs a debounce filter, qualifies accepted level changes against the
// selected edge mode, emits a registered one-cycle pulse per qualified edge,
// and records the event in a sticky flag until it is cleared.
//
// Parameters:
//   NUM_CH          number of independent channels (>= 1)
//   EDGE_MODE       0 = falling, 1 = rising, 2 = both edges
//   DEBOUNCE_CYCLES consecutive differing samples needed to accept a level
//   INIT_LEVEL      reset value of every filtered level / synchronizer flop
//
// Optional build macro:
//   EDGE_DETECTOR_SYNC_EN  inserts a 2-flop synchronizer per channel in
//                          front of the debounce stage (+2 cycles latency)
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          asynchronous active-high reset
//   in             channel inputs
//   clear          per-channel sticky flag clear
//   level          filtered (debounced) level per channel
//   edge_detected  one-cycle registered pulse per qualified edge
//   event_flags    sticky per-channel event record
//   any_event      registered OR of event_flags

module multi_edge_detector #(
  parameter int   NUM_CH          = 8,
  parameter int   EDGE_MODE       = 1,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] in,
  input  logic [NUM_CH-1:0] clear,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] edge_detected,
  output logic [NUM_CH-1:0] event_flags,
  output logic              any_event
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_CH-1:0] INIT_VEC = {NUM_CH{INIT_LEVEL}};

  // Reject illegal configurations at elaboration time.
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("multi_edge_detector: NUM_CH must be >= 1");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("multi_edge_detector: EDGE_MODE must be 0, 1 or 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("multi_edge_detector: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NUM_CH-1:0] samp;

`ifdef EDGE_DETECTOR_SYNC_EN
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;

  // Two-flop synchronizer; the debounce stage only ever sees sync2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= INIT_VEC;
      sync2 <= INIT_VEC;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign samp = sync2;
`else
  assign samp = in;
`endif

  logic [CW-1:0]     cnt [NUM_CH];
  logic [NUM_CH-1:0] differ;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] edge_next;
  logic [NUM_CH-1:0] flags_next;

  // A channel accepts its new level on the sample that completes a run of
  // DEBOUNCE_CYCLES consecutive samples differing from the current level.
  // The accepted value is the sample itself, so its polarity tells us the
  // edge direction.
  always_comb begin
    differ    = samp ^ level;
    accept    = '0;
    edge_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
    if (EDGE_MODE == 2) begin
      edge_next = accept;
    end else if (EDGE_MODE == 1) begin
      edge_next = accept & samp;
    end else begin
      edge_next = accept & ~samp;
    end
    // Set has priority over clear.
    flags_next = (event_flags & ~clear) | edge_detected;
  end

  // Debounce counters and filtered levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= INIT_VEC;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!differ[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          level[i] <= samp[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pulse goes out on the accepting edge; the sticky flag follows one cycle
  // later, and any_event is built from the next-state flags so it lines up
  // with event_flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_detected <= '0;
      event_flags   <= '0;
      any_event     <= 1'b0;
    end else begin
      edge_detected <= edge_next;
      event_flags   <= flags_next;
      any_event     <= |flags_next;
    end
  end

endmodule
